// File: rtl/scan_sched.sv
`default_nettype none
// ============================================================================
// Module  : scan_sched
// Brief   : Two-requester round-robin scan scheduler that halts the DUT clock
//           around one scan-engine run, with length reject and RUN watchdog.
// Rev     : 1.0  initial release
// ============================================================================
module scan_sched #(
  parameter int HALT_CYC = 4,
  parameter int TO_W     = 24
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [1:0]      req,
  input  logic [15:0]     len0,
  input  logic [15:0]     len1,
  input  logic [TO_W-1:0] timeout_cycles,
  output logic [1:0]      ack,
  output logic [1:0]      err,
  output logic [1:0]      grant,
  output logic            scan_start,
  output logic [15:0]     scan_length,
  input  logic            scan_done,
  output logic            dut_halt,
  output logic            busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_HALT    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_ACK     = 3'd6;

  localparam logic [3:0]      c_HALT_LOAD = 4'(HALT_CYC - 1);
  localparam logic [TO_W-1:0] c_BLANK     = TO_W'(2);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [3:0]      r_cnt;
  logic [TO_W-1:0] r_run;
  logic [TO_W-1:0] r_to;
  logic [1:0]      r_req_lat;
  logic            r_owner;
  logic            r_last;
  logic            r_err_flag;

  logic [1:0]      r_ack;
  logic [1:0]      r_err;
  logic [1:0]      r_grant;
  logic            r_start;
  logic [15:0]     r_len;
  logic            r_halt;
  logic            r_busy;

  logic            w_win;
  logic [15:0]     w_len;
  logic            w_reject;
  logic [TO_W-1:0] w_run_inc;
  logic            w_done_ok;
  logic            w_timeout;
  logic            w_own;
  logic [1:0]      w_own_oh;
  logic            w_err_now;
  logic            w_cnt_load;

  // Single requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    w_win = ~r_last;
    case (r_req_lat)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      default: w_win = ~r_last;
    endcase
  end

  assign w_len     = w_win ? len1 : len0;
  assign w_reject  = (w_len < 16'd2);
  assign w_run_inc = (&r_run) ? r_run : r_run + 1'b1;
  assign w_done_ok = scan_done && (r_run >= c_BLANK);
  assign w_timeout = (r_to != '0) && (w_run_inc == r_to);
  assign w_own     = (r_state == S_ARB) ? w_win : r_owner;
  assign w_own_oh  = w_own ? 2'b10 : 2'b01;
  assign w_err_now = (r_state == S_ARB) ? w_reject : r_err_flag;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req != 2'b00) w_next = S_ARB;
      S_ARB:     w_next = w_reject ? S_ACK : S_HALT;
      S_HALT:    if (r_cnt == 4'd0) w_next = S_START;
      S_START:   w_next = S_RUN;
      S_RUN:     if (w_done_ok || w_timeout) w_next = S_RELEASE;
      S_RELEASE: if (r_cnt == 4'd0) w_next = S_ACK;
      S_ACK:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_cnt_load = ((w_next == S_HALT)    && (r_state != S_HALT)) ||
                      ((w_next == S_RELEASE) && (r_state != S_RELEASE));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_run   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_load)
        r_cnt <= c_HALT_LOAD;
      else if (r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_RUN)
        r_run <= w_run_inc;
      else
        r_run <= '0;
    end
  end

  // Operation context is frozen in ARB so later input changes cannot leak in.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_req_lat  <= 2'b00;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_err_flag <= 1'b0;
      r_to       <= '0;
      r_len      <= 16'd0;
    end else begin
      if (r_state == S_IDLE)
        r_req_lat <= req;
      if (r_state == S_ARB) begin
        r_owner    <= w_win;
        r_err_flag <= w_reject;
        r_to       <= timeout_cycles;
        r_len      <= w_len;
      end
      if ((r_state == S_RUN) && w_timeout && !w_done_ok)
        r_err_flag <= 1'b1;
      if (r_state == S_ACK)
        r_last <= r_owner;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ack   <= 2'b00;
      r_err   <= 2'b00;
      r_grant <= 2'b00;
      r_start <= 1'b0;
      r_halt  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack   <= (w_next == S_ACK) ? w_own_oh : 2'b00;
      r_err   <= ((w_next == S_ACK) && w_err_now) ? w_own_oh : 2'b00;
      if (r_state == S_ARB)
        r_grant <= w_own_oh;
      else if (r_state == S_ACK)
        r_grant <= 2'b00;
      r_start <= (w_next == S_START);
      r_halt  <= (w_next == S_HALT) || (w_next == S_START) ||
                 (w_next == S_RUN)  || (w_next == S_RELEASE);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  assign ack         = r_ack;
  assign err         = r_err;
  assign grant       = r_grant;
  assign scan_start  = r_start;
  assign scan_length = r_len;
  assign dut_halt    = r_halt;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/scan_sched.md
SCAN_SCHED -- requirements
Module: scan_sched

Interface
REQ-001 Parameter HALT_CYC, default 4, SHALL set the number of cycles dut_halt is held before scan_start and after scan completion (range 1..15).
REQ-002 Parameter TO_W, default 24, SHALL set the width of the timeout counter and of timeout_cycles.
REQ-003 aclk  in  1  single clock; every flop SHALL be rising-edge on aclk.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  2  level request per requester (bit0 = snapshot agent, bit1 = restore agent).
REQ-006 len0, len1  in  16 each  scan length in bits for requester 0 and requester 1.
REQ-007 timeout_cycles  in  TO_W  RUN-phase watchdog limit; 0 disables the watchdog.
REQ-008 ack  out  2  one-cycle completion pulse per requester.
REQ-009 err  out  2  one-cycle error pulse per requester, coincident with ack.
REQ-010 grant  out  2  one-hot owner of the scan engine, held from ARB exit to ACK exit.
REQ-011 scan_start  out  1  one-cycle start pulse to the scan engine.
REQ-012 scan_length  out  16  registered length to the scan engine, stable from HALT through RELEASE.
REQ-013 scan_done  in  1  scan engine done indication (level).
REQ-014 dut_halt  out  1  stops the DUT clock while the chain is shifted.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ARB, HALT, START, RUN, RELEASE, ACK.
REQ-017 IDLE -> ARB SHALL occur on the first cycle with req != 0.
REQ-018 ARB SHALL take one cycle and grant round-robin: a single request wins outright; with both bits set, the requester not granted last wins.
REQ-019 In ARB, the winner's len SHALL be latched into scan_length.
REQ-020 If the latched length is 0 or 1, ARB SHALL go directly to ACK with err set for the winner; dut_halt and scan_start SHALL not assert.
REQ-021 HALT SHALL assert dut_halt and hold for exactly HALT_CYC cycles, then go to START.
REQ-022 START SHALL assert scan_start for exactly one cycle, then go to RUN.
REQ-023 RUN SHALL ignore scan_done for its first 2 cycles (blanking) and exit to RELEASE on the first sampled scan_done = 1 after blanking.
REQ-024 The RUN cycle counter SHALL start at 0 on RUN entry, saturate at all-ones, and not wrap.
REQ-025 If timeout_cycles != 0 and the RUN cycle count equals timeout_cycles before scan_done, RUN SHALL exit to RELEASE and flag err for the owner.
REQ-026 RELEASE SHALL keep dut_halt high for HALT_CYC cycles, deassert it on exit, then go to ACK.
REQ-027 dut_halt SHALL be high from HALT entry through the last RELEASE cycle, and low otherwise.
REQ-028 ACK SHALL last one cycle and pulse ack[owner], plus err[owner] if flagged; it SHALL then clear grant, update the last-granted pointer and return to IDLE.
REQ-029 End-to-end latency for a non-error request SHALL be 1 (ARB) + HALT_CYC + 1 (START) + RUN cycles + HALT_CYC + 1 (ACK) cycles.
REQ-030 Deasserting req mid-operation SHALL not abort the operation; ack SHALL still pulse.
REQ-031 A req still high in the cycle after ACK SHALL be treated as a new request.
REQ-032 Changes to len0, len1 or timeout_cycles after ARB SHALL have no effect on the current operation.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While aresetn = 0, the block SHALL immediately hold: state IDLE; ack, err, grant = 0; scan_start = 0; dut_halt = 0; busy = 0; scan_length = 0; last-granted pointer = requester 1, so requester 0 wins the first tie.
REQ-035 Reset asserted mid-operation SHALL drop dut_halt asynchronously and produce no ack.
REQ-036 After aresetn deasserts, the first state transition SHALL occur on the first aclk edge.

Verification
REQ-037 Single request: req=01, len0=100, HALT_CYC=4, scan_done rises 50 cycles after scan_start -> grant=01; dut_halt high 4 cycles before scan_start; ack[0] pulses 5 cycles after done is sampled; err=0.
REQ-038 Tie and fairness: req=11 from reset, held high -> grants in order 01, 10, 01, 10; scan_length follows len0 and len1 accordingly.
REQ-039 Length reject: len1=1 with req=10 -> ack[1] and err[1] pulse 2 cycles after req; dut_halt and scan_start never assert.
REQ-040 Timeout: timeout_cycles=20, scan_done held 0 -> RELEASE entered after 20 RUN cycles; ack[0] and err[0] pulse; dut_halt drops.
REQ-041 Early done: scan_done tied 1 -> first 2 RUN cycles ignored; RUN lasts exactly 3 cycles.
REQ-042 Reset mid-RUN: aresetn pulled low -> dut_halt, busy and grant go 0 without waiting for a clock edge; no ack; a fresh request after release is served normally.
